// File: rtl/mvm_ctrl_if.sv
// Stream handshake bundle for the matrix-vector multiplier controller.
//   s_valid_in  : input word valid (from the stream source)
//   s_ready_out : controller accepts an input word
//   m_ready_in  : downstream accepts the current y element
//   m_valid_out : a completed y element is available
//   row_out     : index of the y element being presented
// Modport slave is the controller side, master is the stream/downstream side.
interface mvm_ctrl_if #(
    parameter int unsigned RW = 2
) ();
    logic          s_valid_in;
    logic          s_ready_out;
    logic          m_ready_in;
    logic          m_valid_out;
    logic [RW-1:0] row_out;

    modport slave (
        input  s_valid_in,
        input  m_ready_in,
        output s_ready_out,
        output m_valid_out,
        output row_out
    );

    modport master (
        output s_valid_in,
        output m_ready_in,
        input  s_ready_out,
        input  m_valid_out,
        input  row_out
    );
endinterface

// File: rtl/mvm_ctrl.sv
// Sequencing controller for a matrix-vector multiplier datapath.
// Loads A (row-major) then x from the input stream, issues one read address
// pair per cycle per row, drives the MAC enables one cycle behind the issue
// (1-cycle memory read latency) and presents each y element on a
// valid/ready handshake.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave)         : s_valid_in/s_ready_out, m_ready_in/m_valid_out, row_out
//   wr_en_a, addr_a     : matrix memory write enable / address (write and read)
//   wr_en_x, addr_x     : vector memory write enable / address (write and read)
//   en_acc, clear_acc   : MAC update enable; clear_acc loads product instead of adding
//   busy                : high while computing, draining or presenting a result
module mvm_ctrl #(
    parameter int unsigned NROWS_A = 4,
    parameter int unsigned NCOLS_A = 4,
    parameter int unsigned AW_A    = (NROWS_A * NCOLS_A > 1) ? $clog2(NROWS_A * NCOLS_A) : 1,
    parameter int unsigned AW_X    = (NCOLS_A > 1) ? $clog2(NCOLS_A) : 1,
    parameter int unsigned RW      = (NROWS_A > 1) ? $clog2(NROWS_A) : 1
) (
    input  logic            clk,
    input  logic            reset,
    mvm_ctrl_if.slave       bus,
    output logic            wr_en_a,
    output logic [AW_A-1:0] addr_a,
    output logic            wr_en_x,
    output logic [AW_X-1:0] addr_x,
    output logic            en_acc,
    output logic            clear_acc,
    output logic            busy
);

    typedef enum logic [2:0] {
        StLoadA,
        StLoadX,
        StComp,
        StDrain,
        StOut
    } state_e;

    localparam logic [AW_A-1:0] LastA   = AW_A'(NROWS_A * NCOLS_A - 1);
    localparam logic [AW_A-1:0] LastX   = AW_A'(NCOLS_A - 1);
    localparam logic [AW_X-1:0] LastCol = AW_X'(NCOLS_A - 1);
    localparam logic [RW-1:0]   LastRow = RW'(NROWS_A - 1);

    state_e          state_q, state_d;
    // Shared counter: load address in the load states, issue address in COMP.
    logic [AW_A-1:0] cnt_q, cnt_d;
    logic [AW_X-1:0] col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            en_acc_q, clear_acc_q;
    logic            issue;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        col_d           = col_q;
        row_d           = row_q;
        issue           = 1'b0;
        bus.s_ready_out = 1'b0;
        bus.m_valid_out = 1'b0;
        bus.row_out     = '0;
        wr_en_a         = 1'b0;
        wr_en_x         = 1'b0;
        addr_a          = '0;
        addr_x          = '0;
        busy            = 1'b0;

        case (state_q)
            StLoadA: begin
                bus.s_ready_out = 1'b1;
                wr_en_a         = bus.s_valid_in;
                addr_a          = cnt_q;
                if (bus.s_valid_in) begin
                    if (cnt_q == LastA) begin
                        cnt_d   = '0;
                        state_d = StLoadX;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StLoadX: begin
                bus.s_ready_out = 1'b1;
                wr_en_x         = bus.s_valid_in;
                addr_x          = cnt_q[AW_X-1:0];
                if (bus.s_valid_in) begin
                    if (cnt_q == LastX) begin
                        cnt_d   = '0;
                        col_d   = '0;
                        row_d   = '0;
                        state_d = StComp;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StComp: begin
                busy   = 1'b1;
                issue  = 1'b1;
                addr_a = cnt_q;
                addr_x = col_q;
                // Issue counter keeps running so it lands on the next row start.
                cnt_d  = cnt_q + 1'b1;
                if (col_q == LastCol) begin
                    col_d   = '0;
                    state_d = StDrain;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            StDrain: begin
                busy    = 1'b1;
                state_d = StOut;
            end
            StOut: begin
                busy            = 1'b1;
                bus.m_valid_out = 1'b1;
                bus.row_out     = row_q;
                if (bus.m_ready_in) begin
                    col_d = '0;
                    if (row_q == LastRow) begin
                        cnt_d   = '0;
                        row_d   = '0;
                        state_d = StLoadA;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = StComp;
                    end
                end
            end
            default: begin
                state_d = StLoadA;
            end
        endcase

        // All outputs read as zero while reset is asserted.
        if (reset) begin
            bus.s_ready_out = 1'b0;
            bus.m_valid_out = 1'b0;
            bus.row_out     = '0;
            wr_en_a         = 1'b0;
            wr_en_x         = 1'b0;
            addr_a          = '0;
            addr_x          = '0;
            busy            = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StLoadA;
            cnt_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            en_acc_q    <= 1'b0;
            clear_acc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            // Delayed one cycle to line up with the registered memory read data.
            en_acc_q    <= issue;
            clear_acc_q <= issue && (col_q == '0);
        end
    end

    assign en_acc    = en_acc_q && !reset;
    assign clear_acc = clear_acc_q && !reset;

endmodule
